// File: rtl/multi_clk_divider.sv
// multi_clk_divider
// NUM_CH independent toggle dividers sharing one input clock. Each channel produces a
// 50% duty divided clock with programmable half-period. The divisor is shadowed and only
// reloaded at a full-period boundary, so a mid-period change never distorts a phase.
// Channels start and stop gracefully: a high phase is never truncated by dropping en.
//
// Ports:
//   inclk          system clock, all state changes on posedge
//   Reset          asynchronous active-low reset
//   en             per-channel run request
//   div_clk_count  per-channel half-period in inclk cycles, channel i at [i*CNT_W +: CNT_W]
//   sync           one-cycle pulse, realigns every running channel to phase 0
//   outclk         divided clock per channel (registered)
//   outclk_Not     registered complement of outclk
//   rise_stb       one-cycle pulse in the cycle outclk[i] becomes 1
//   active         channel is not idle
//   count_check    per-channel live counter, for debug
module multi_clk_divider #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                    inclk,
  input  logic                    Reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] div_clk_count,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       outclk,
  output logic [NUM_CH-1:0]       outclk_Not,
  output logic [NUM_CH-1:0]       rise_stb,
  output logic [NUM_CH-1:0]       active,
  output logic [NUM_CH*CNT_W-1:0] count_check
);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] act_div_q;
    logic             out_q;
    logic             out_n_q;
    logic             rise_q;
    logic [CNT_W-1:0] div;
    logic             tc;

    assign div = div_clk_count[i*CNT_W +: CNT_W];
    // Last cycle of the current half-period; act_div_q is never 0 outside idle.
    assign tc  = (cnt_q == act_div_q - CntOne);

    always_ff @(posedge inclk or negedge Reset) begin
      if (!Reset) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        act_div_q <= '0;
        out_q     <= 1'b0;
        out_n_q   <= 1'b1;
        rise_q    <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        if (sync && (state_q != StIdle)) begin
          // Realign to phase 0; takes precedence over any toggle due this cycle.
          cnt_q     <= '0;
          out_q     <= 1'b0;
          out_n_q   <= 1'b1;
          act_div_q <= div;
          if ((state_q == StStop) || (div == '0)) begin
            state_q <= StIdle;
          end else begin
            state_q <= StRun;
          end
        end else begin
          unique case (state_q)
            StIdle: begin
              act_div_q <= div;
              cnt_q     <= '0;
              out_q     <= 1'b0;
              out_n_q   <= 1'b1;
              if (en[i] && (div != '0)) begin
                state_q <= StRun;
              end
            end
            StRun, StStop: begin
              if (!en[i] && !out_q) begin
                // Stop request while low: nothing to finish. Only reachable from run,
                // since a stopping channel is always high.
                state_q <= StIdle;
                cnt_q   <= '0;
              end else if (tc) begin
                cnt_q   <= '0;
                out_q   <= ~out_q;
                out_n_q <= out_q;
                if (out_q) begin
                  // Falling toggle closes a full period: safe point to reload or stop.
                  act_div_q <= div;
                  if (!en[i] || (div == '0)) begin
                    state_q <= StIdle;
                  end else begin
                    state_q <= StRun;
                  end
                end else begin
                  rise_q  <= 1'b1;
                  state_q <= StRun;
                end
              end else begin
                cnt_q   <= cnt_q + CntOne;
                state_q <= en[i] ? StRun : StStop;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end

    assign outclk[i]                       = out_q;
    assign outclk_Not[i]                   = out_n_q;
    assign rise_stb[i]                     = rise_q;
    assign active[i]                       = (state_q != StIdle);
    assign count_check[i*CNT_W +: CNT_W]   = cnt_q;
  end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Self-checking bench for multi_clk_divider: a directed vector table on channel 0,
// hand-written multi-cycle corner cases, and randomized traffic against a phase-position
// reference model (each running channel is a position k within a 2N-cycle period).
module tb_multi_clk_divider;

  localparam int unsigned NumCh = 4;
  localparam int unsigned CntW  = 32;
  localparam int NumVec = 23;

  logic                   inclk = 1'b0;
  logic                   Reset = 1'b0;
  logic                   sync  = 1'b0;
  logic [NumCh-1:0]       en    = '0;
  logic [CntW-1:0]        div_v [NumCh];
  logic [NumCh*CntW-1:0]  div_clk_count;
  logic [NumCh-1:0]       outclk;
  logic [NumCh-1:0]       outclk_Not;
  logic [NumCh-1:0]       rise_stb;
  logic [NumCh-1:0]       active;
  logic [NumCh*CntW-1:0]  count_check;

  for (genvar g = 0; g < NumCh; g++) begin : g_div
    assign div_clk_count[g*CntW +: CntW] = div_v[g];
  end

  multi_clk_divider #(
    .NUM_CH(NumCh),
    .CNT_W (CntW)
  ) dut (
    .inclk        (inclk),
    .Reset        (Reset),
    .en           (en),
    .div_clk_count(div_clk_count),
    .sync         (sync),
    .outclk       (outclk),
    .outclk_Not   (outclk_Not),
    .rise_stb     (rise_stb),
    .active       (active),
    .count_check  (count_check)
  );

  always #5 inclk = ~inclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: position k inside the current 2N-cycle period.
  bit               m_on   [NumCh];
  bit               m_stop [NumCh];
  longint unsigned  m_k    [NumCh];
  longint unsigned  m_n    [NumCh];

  task automatic model_reset();
    for (int c = 0; c < NumCh; c++) begin
      m_on[c] = 0; m_stop[c] = 0; m_k[c] = 0; m_n[c] = 0;
    end
  endtask

  // Advance the model by one inclk edge using the inputs currently applied.
  task automatic model_edge();
    if (!Reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NumCh; c++) begin
      longint unsigned d;
      d = longint'(div_v[c]);
      if (sync && m_on[c]) begin
        if (m_stop[c] || d == 0) m_on[c] = 0;
        m_k[c] = 0; m_n[c] = d; m_stop[c] = 0;
      end else if (!m_on[c]) begin
        if (en[c] && d != 0) begin
          m_on[c] = 1; m_k[c] = 0; m_n[c] = d; m_stop[c] = 0;
        end
      end else if (!en[c] && m_k[c] < m_n[c]) begin
        m_on[c] = 0; m_k[c] = 0; m_stop[c] = 0;
      end else begin
        m_k[c]    = m_k[c] + 1;
        m_stop[c] = !en[c];
        if (m_k[c] == 2 * m_n[c]) begin
          m_k[c] = 0; m_n[c] = d; m_stop[c] = 0;
          if (!en[c] || d == 0) m_on[c] = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < NumCh; c++) begin
      logic            e_out, e_rise, e_act;
      logic [CntW-1:0] e_cnt;
      logic [CntW-1:0] got_cnt;
      e_act  = m_on[c];
      e_out  = m_on[c] && (m_k[c] >= m_n[c]);
      e_rise = m_on[c] && (m_k[c] == m_n[c]);
      if (!m_on[c])              e_cnt = '0;
      else if (m_k[c] >= m_n[c]) e_cnt = CntW'(m_k[c] - m_n[c]);
      else                       e_cnt = CntW'(m_k[c]);
      got_cnt = count_check[c*CntW +: CntW];
      n_checks++;
      if (outclk[c] !== e_out || outclk_Not[c] !== ~e_out || rise_stb[c] !== e_rise ||
          active[c] !== e_act || got_cnt !== e_cnt) begin
        $display("FAIL %s ch%0d t=%0t: got out=%b nout=%b rise=%b act=%b cnt=%0d, want out=%b nout=%b rise=%b act=%b cnt=%0d",
                 tag, c, $time, outclk[c], outclk_Not[c], rise_stb[c], active[c], got_cnt,
                 e_out, ~e_out, e_rise, e_act, e_cnt);
      end else begin
        n_pass++;
      end
    end
  endtask

  task automatic chk(input string name, input longint got, input longint want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got %0d want %0d", name, got, want);
    else n_pass++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge inclk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    en    = '0;
    sync  = 1'b0;
    for (int c = 0; c < NumCh; c++) div_v[c] = '0;
    model_reset();
    @(posedge inclk);
    #1;
    Reset = 1'b1;
  endtask

  typedef struct {
    logic            en;
    logic [CntW-1:0] dv;
    logic            sy;
    logic            e_out;
    logic [CntW-1:0] e_cnt;
    logic            e_rise;
    logic            e_act;
  } vec_t;

  vec_t vecs [NumVec];

  function automatic vec_t mk(logic e, int unsigned d, logic s, logic o, int unsigned cn,
                              logic r, logic a);
    vec_t v;
    v.en = e; v.dv = CntW'(d); v.sy = s; v.e_out = o; v.e_cnt = CntW'(cn);
    v.e_rise = r; v.e_act = a;
    return v;
  endfunction

  initial begin : main
    int t0, t1, nbad, r1, r2, hi_cnt;
    bit exp_o;

    // Reset state, sampled while Reset is held low.
    for (int c = 0; c < NumCh; c++) div_v[c] = '0;
    model_reset();
    @(posedge inclk);
    #1;
    check_all("reset");

    // Channel 0 vectors: {en, div, sync} -> {outclk, cnt, rise_stb, active} after the edge.
    vecs[0]  = mk(1, 3, 0, 0, 0, 0, 1);  // enter run
    vecs[1]  = mk(1, 3, 0, 0, 1, 0, 1);
    vecs[2]  = mk(1, 3, 0, 0, 2, 0, 1);
    vecs[3]  = mk(1, 3, 0, 1, 0, 1, 1);  // 3rd edge: rise
    vecs[4]  = mk(1, 3, 0, 1, 1, 0, 1);
    vecs[5]  = mk(1, 3, 0, 1, 2, 0, 1);
    vecs[6]  = mk(1, 3, 0, 0, 0, 0, 1);  // fall, period 6
    vecs[7]  = mk(1, 3, 0, 0, 1, 0, 1);
    vecs[8]  = mk(1, 3, 0, 0, 2, 0, 1);
    vecs[9]  = mk(1, 3, 0, 1, 0, 1, 1);
    vecs[10] = mk(0, 3, 0, 1, 1, 0, 1);  // en dropped while high: keep going
    vecs[11] = mk(0, 3, 0, 1, 2, 0, 1);
    vecs[12] = mk(1, 3, 0, 0, 0, 0, 1);  // en back before the fall: still running
    vecs[13] = mk(0, 3, 0, 0, 0, 0, 0);  // en dropped while low: idle at once
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 0);  // divide by zero never runs
    vecs[15] = mk(1, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, 2, 0, 0, 0, 0, 1);
    vecs[17] = mk(1, 2, 0, 0, 1, 0, 1);
    vecs[18] = mk(1, 2, 1, 0, 0, 0, 1);  // sync beats the due rise
    vecs[19] = mk(1, 2, 0, 0, 1, 0, 1);
    vecs[20] = mk(1, 2, 0, 1, 0, 1, 1);
    vecs[21] = mk(0, 2, 0, 1, 1, 0, 1);  // stopping
    vecs[22] = mk(0, 2, 0, 0, 0, 0, 0);  // fall completes, idle

    Reset = 1'b1;
    for (int r = 0; r < NumVec; r++) begin
      logic [CntW-1:0] got_cnt;
      en[0] = vecs[r].en; div_v[0] = vecs[r].dv; sync = vecs[r].sy;
      tick();
      got_cnt = count_check[CntW-1:0];
      n_checks++;
      if (outclk[0] !== vecs[r].e_out || outclk_Not[0] !== ~vecs[r].e_out ||
          got_cnt !== vecs[r].e_cnt || rise_stb[0] !== vecs[r].e_rise ||
          active[0] !== vecs[r].e_act) begin
        $display("FAIL vec%0d: got out=%b nout=%b cnt=%0d rise=%b act=%b, want out=%b cnt=%0d rise=%b act=%b",
                 r, outclk[0], outclk_Not[0], got_cnt, rise_stb[0], active[0],
                 vecs[r].e_out, vecs[r].e_cnt, vecs[r].e_rise, vecs[r].e_act);
      end else begin
        n_pass++;
      end
    end
    sync = 1'b0;

    // Channels 1 (div 1) and 2 (div 5) side by side.
    do_reset();
    en[1] = 1; div_v[1] = 1; en[2] = 1; div_v[2] = 5;
    tick();
    r1 = 0; r2 = 0; nbad = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (rise_stb[1]) r1++;
      if (rise_stb[2]) r2++;
      if (outclk_Not !== ~outclk) nbad++;
    end
    chk("ch1_rises", r1, 10);
    chk("ch2_rises", r2, 2);
    chk("complement", nbad, 0);

    // Divisor 4 -> 2 while high: current period untouched, new phases from next period.
    do_reset();
    en[3] = 1; div_v[3] = 4;
    tick();
    for (int j = 1; j <= 14; j++) begin
      if (j == 5) div_v[3] = 2;
      tick();
      exp_o = (j >= 4 && j < 8) || (j >= 10 && j < 12) || (j >= 14);
      chk($sformatf("reload_e%0d", j), outclk[3], exp_o);
    end

    // Drop en in the 2nd high cycle of a 4-cycle phase: full high phase, then idle.
    do_reset();
    en[0] = 1; div_v[0] = 4;
    tick();
    for (int j = 1; j <= 5; j++) tick();
    en[0] = 0;
    hi_cnt = 2;
    for (int j = 0; j < 8 && outclk[0]; j++) begin
      tick();
      if (outclk[0]) hi_cnt++;
    end
    chk("stop_high_len", hi_cnt, 4);
    chk("stop_idle", active[0], 0);

    // Running channel reloaded with 0 stops at its falling edge.
    do_reset();
    en[2] = 1; div_v[2] = 2;
    tick();
    tick(); tick();
    div_v[2] = 0;
    tick();
    chk("zero_reload_hold", {active[2], outclk[2]}, 2'b11);
    tick();
    chk("zero_reload_idle", {active[2], outclk[2]}, 2'b00);

    // sync at an arbitrary phase on channels 0 (div 3) and 1 (div 7).
    do_reset();
    en[0] = 1; div_v[0] = 3; en[1] = 1; div_v[1] = 7;
    tick();
    for (int j = 0; j < int'($urandom_range(3, 20)); j++) tick();
    sync = 1;
    tick();
    sync = 0;
    chk("sync_cnt0", count_check[CntW-1:0], 0);
    chk("sync_cnt1", count_check[2*CntW-1:CntW], 0);
    chk("sync_out", outclk[1:0], 0);
    t0 = 0; t1 = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (rise_stb[0] && t0 == 0) t0 = t;
      if (rise_stb[1] && t1 == 0) t1 = t;
    end
    chk("sync_rise0", t0, 3);
    chk("sync_rise1", t1, 7);

    // Asynchronous reset in the middle of a high phase.
    do_reset();
    en[0] = 1; div_v[0] = 3;
    for (int j = 0; j < 5; j++) tick();
    chk("pre_reset_high", outclk[0], 1);
    #2;
    Reset = 0;
    #1;
    chk("async_rst_out", outclk[0], 0);
    chk("async_rst_nout", outclk_Not[0], 1);
    chk("async_rst_act", active[0], 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < NumCh; c++) begin
      en[c] = 1;
      div_v[c] = CntW'($urandom_range(1, 6));
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NumCh; c++) begin
        if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
        if ($urandom_range(0, 24) == 0) div_v[c] = CntW'($urandom_range(0, 6));
      end
      sync = ($urandom_range(0, 59) == 0);
      tick();
      check_all("rand");
    end
    sync = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_clk_divider.md
Name: multi_clk_divider

Overview:
Parametrised, multi-channel successor to the single-channel toggle divider. It generates NUM_CH independent divided clocks from one input clock. Each channel has a programmable half-period, a glitch-free shadowed divisor reload, graceful enable and disable, and a global phase-realign strobe. It sits at the top level and feeds slow enables and clocks to display, debounce and LED logic.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 32, width of per-channel divisor and counter

Ports:
inclk  input  1  system clock; all state changes on posedge
Reset  input  1  asynchronous active-low reset
en  input  NUM_CH  per-channel run request
div_clk_count  input  NUM_CH*CNT_W  per-channel half-period in inclk cycles; channel i at bits [i*CNT_W +: CNT_W]
sync  input  1  one-cycle pulse; realigns all channels to phase 0
outclk  output  NUM_CH  divided clock per channel (registered)
outclk_Not  output  NUM_CH  registered complement of outclk
rise_stb  output  NUM_CH  one-cycle pulse in the cycle outclk[i] becomes 1
active  output  NUM_CH  channel state is not IDLE
count_check  output  NUM_CH*CNT_W  per-channel live counter, for debug

Behaviour:
- Reset is asynchronous and active-low; clock is inclk. While Reset=0, every channel has state=IDLE, cnt=0, act_div=0, outclk=0, outclk_Not=1, rise_stb=0, active=0, count_check=0.
- Priority at each edge: Reset > sync > per-channel FSM.
- Per-channel registers: state (IDLE, RUN, STOP), cnt[CNT_W-1:0], and act_div, the shadow divisor.
- outclk_Not always equals ~outclk. The two are never equal in any cycle.
- IDLE:
  - act_div <= div_clk_count[i] every cycle; cnt <= 0; outclk=0.
  - If en[i]=1 and div_clk_count[i]!=0: go to RUN with cnt <= 0 and no toggle.
  - If en[i]=1 and the divisor is 0: stay IDLE. Divide-by-zero is never executed.
- RUN and STOP counting rule:
  - If cnt == act_div-1: cnt <= 0 and toggle outclk. Otherwise cnt <= cnt+1.
  - Result: outclk is high for N cycles and low for N cycles, period 2N, where N=act_div. The first rising toggle occurs on the Nth edge after entry to RUN. N=1 gives inclk/2.
- Reload: act_div <= div_clk_count[i] only on a falling toggle (outclk 1->0), i.e. at a full-period boundary. A divisor change mid-period never shortens or stretches the current high or low phase.
  - If the reloaded value is 0, the channel goes to IDLE at that edge.
- RUN with en[i]=0:
  - If outclk=0: go to IDLE at that edge; cnt <= 0.
  - If outclk=1: go to STOP.
- STOP: keeps counting. On the falling toggle, go to IDLE (outclk=0, cnt <= 0). If en[i] returns to 1 before then, go back to RUN with no disturbance to cnt or outclk.
- Consequence: no high phase is ever truncated, so the output is glitch-free.
- sync=1: every channel not in IDLE is forced to cnt <= 0, outclk <= 0, act_div <= div_clk_count[i], and stays in RUN; a STOP channel goes to IDLE. IDLE channels are unaffected. sync overrides a toggle due in the same cycle.
- rise_stb[i] is registered and high exactly in the cycles where outclk[i] went 0->1 at the same edge.
- active[i] = (state != IDLE). count_check slice i = cnt.
- Counter arithmetic is unsigned CNT_W. cnt never exceeds act_div-1, so no wrap occurs. The maximum divisor is 2^CNT_W-1.
- Reset asserted mid-period: outputs return to reset values immediately (asynchronously). After release, a channel restarts from IDLE.
- Channels are fully independent apart from the shared sync.

Test Plan:
- Reset then en[0]=1 with div=3: outclk[0] rises on the 3rd edge after RUN entry, then 3 cycles high and 3 low (period 6). rise_stb[0] pulses once per period. outclk_Not[0] is always the complement.
- div=1 on channel 1 and div=5 on channel 2 concurrently: channel 1 period 2, channel 2 period 10, with no interaction between them.
- Channel running with div=4; change div to 2 while outclk is high: the current high phase lasts 4 cycles and the low phase 4 cycles, then new phases are 2 cycles each starting at the next period.
- Drop en during the 2nd cycle of a 4-cycle high phase: the high phase completes its full 4 cycles, then IDLE with active=0. Re-raising en during STOP causes no glitch.
- en=1 with div=0: active stays 0 and outclk stays 0. A running channel reloaded with 0 stops at the falling edge.
- Channels 0 (div 3) and 1 (div 7) at arbitrary phases, pulse sync: both show cnt=0 and outclk=0 next cycle, then rise together after 3 and 7 edges respectively. Asserting Reset mid-high forces outclk=0 and outclk_Not=1 asynchronously.
